memory_arbiter: RTL and testbench

Two-port round-robin controller for the single-ported `Memory` register file (N-bit cells, 2^M deep, shared tri-state DataBus). It sits between two requesters (e.g. the datapath and a loader/debug port) and the memory. It serialises their read/write transactions, drives `Select`, `RW` and the bus, and returns read data with a one-cycle `Ack` pulse. Requesters never touch the memory bus directly.

---
 rtl/memory_arbiter_pkg.sv | 20 ++
 rtl/rr_arbiter2.sv | 29 ++
 rtl/memory_arbiter.sv | 144 ++++++++++++++
 tb/tb_memory_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg
//   Shared definitions for the two-port memory arbiter:
//   - FSM state encodings and the enumerated state type
//   - requester port indices
package memory_arbiter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ACCESS = 2'b01;
  localparam logic [1:0] ST_DONE   = 2'b10;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_ACCESS = ST_ACCESS,
    S_DONE   = ST_DONE
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
//   Combinational two-way round-robin arbiter.
//   Ports:
//     req0, req1 : request levels from port 0 / port 1
//     last       : index of the port granted most recently
//     grant      : index of the winning port (meaningful when valid = 1)
//     valid      : at least one request is pending
module rr_arbiter2
  import memory_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
    grant = PORT0;
    if (req0 && req1) begin
      // Tie: the port that did not win last time goes next.
      grant = (last == PORT0) ? PORT1 : PORT0;
    end else if (req1) begin
      grant = PORT1;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Serialises read/write transactions from two requesters onto a single-ported
//   register-file memory with a shared tri-state data bus.
//   Ports:
//     Clock, ResetN          : posedge clock, asynchronous active-low reset
//     Req0/Req1              : request levels, held until the matching Ack
//     Wr0/Wr1                : 1 = write, 0 = read
//     Addr0/Addr1            : cell address (M bits)
//     WData0/WData1          : write data (N bits)
//     Ack0/Ack1              : one-cycle completion pulses
//     RData                  : data of the last completed read
//     MemSelect, MemRW       : memory address and write strobe
//     MemData                : shared memory data bus (driven only on writes)
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 2
) (
  input  logic         Clock,
  input  logic         ResetN,
  input  logic         Req0,
  input  logic         Req1,
  input  logic         Wr0,
  input  logic         Wr1,
  input  logic [M-1:0] Addr0,
  input  logic [M-1:0] Addr1,
  input  logic [N-1:0] WData0,
  input  logic [N-1:0] WData1,
  output logic         Ack0,
  output logic         Ack1,
  output logic [N-1:0] RData,
  output logic [M-1:0] MemSelect,
  output logic         MemRW,
  inout  logic [N-1:0] MemData
);

  state_e       state_q, state_d;
  logic         last_q, last_d;
  logic         port_q, port_d;
  logic         wr_q, wr_d;
  logic [M-1:0] addr_q, addr_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic         ack0_q, ack0_d;
  logic         ack1_q, ack1_d;
  logic [N-1:0] rdata_q, rdata_d;
  logic [M-1:0] mem_select_q, mem_select_d;
  logic         mem_rw_q, mem_rw_d;

  logic arb_grant;
  logic arb_valid;

  rr_arbiter2 u_arb (
    .req0  (Req0),
    .req1  (Req1),
    .last  (last_q),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    port_d       = port_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    mem_select_d = '0;
    mem_rw_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          port_d  = arb_grant;
          last_d  = arb_grant;
          wr_d    = (arb_grant == PORT1) ? Wr1    : Wr0;
          addr_d  = (arb_grant == PORT1) ? Addr1  : Addr0;
          wdata_d = (arb_grant == PORT1) ? WData1 : WData0;
          // Memory controls are registered, so they are loaded here to be
          // valid for exactly the ACCESS cycle.
          mem_select_d = addr_d;
          mem_rw_d     = wr_d;
          state_d      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!wr_q) begin
          rdata_d = MemData;
        end
        ack0_d  = (port_q == PORT0);
        ack1_d  = (port_q == PORT1);
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q      <= S_IDLE;
      last_q       <= PORT1;
      port_q       <= PORT0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      mem_select_q <= '0;
      mem_rw_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      port_q       <= port_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      mem_select_q <= mem_select_d;
      mem_rw_q     <= mem_rw_d;
    end
  end

  assign Ack0      = ack0_q;
  assign Ack1      = ack1_q;
  assign RData     = rdata_q;
  assign MemSelect = mem_select_q;
  assign MemRW     = mem_rw_q;

  // mem_rw_q is high only during an ACCESS write, so the bus is released in
  // every cycle the memory may be driving it, and immediately on reset.
  assign MemData = mem_rw_q ? wdata_q : {N{1'bz}};

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter
//   Directed bench for memory_arbiter with a behavioural 4 x 8-bit memory on
//   the shared bus.
module tb_memory_arbiter;

  logic       Clock;
  logic       ResetN;
  logic       Req0, Req1, Wr0, Wr1;
  logic [1:0] Addr0, Addr1;
  logic [7:0] WData0, WData1;
  logic       Ack0, Ack1;
  logic [7:0] RData;
  logic [1:0] MemSelect;
  logic       MemRW;
  wire  [7:0] mem_data;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] last_rdata;

  memory_arbiter #(.N(8), .M(2)) dut (
    .Clock     (Clock),
    .ResetN    (ResetN),
    .Req0      (Req0),
    .Req1      (Req1),
    .Wr0       (Wr0),
    .Wr1       (Wr1),
    .Addr0     (Addr0),
    .Addr1     (Addr1),
    .WData0    (WData0),
    .WData1    (WData1),
    .Ack0      (Ack0),
    .Ack1      (Ack1),
    .RData     (RData),
    .MemSelect (MemSelect),
    .MemRW     (MemRW),
    .MemData   (mem_data)
  );

  // Behavioural memory: drives the bus whenever RW = 0, stores on RW = 1,
  // clears on reset.
  logic [7:0] mem_q [4];
  always @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= 8'h00;
    end else if (MemRW) begin
      mem_q[MemSelect] <= mem_data;
    end
  end
  assign mem_data = MemRW ? 8'bz : mem_q[MemSelect];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Acks must never coincide.
  always @(negedge Clock) begin
    if (ResetN && (Ack0 || Ack1)) check_val("ack_excl", {31'd0, Ack0 & Ack1}, 32'd0);
  end

  // Single transaction on one port; called at a negedge with the DUT idle.
  task automatic txn(input int p, input logic wr, input logic [1:0] a,
                     input logic [7:0] d, input string tag);
    int  lat;
    bit  got;
    lat = 0;
    got = 0;
    if (p == 0) begin Req0 = 1; Wr0 = wr; Addr0 = a; WData0 = d; end
    else        begin Req1 = 1; Wr1 = wr; Addr1 = a; WData1 = d; end
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      lat++;
      if ((p == 0) ? Ack0 : Ack1) begin got = 1; break; end
    end
    last_rdata = RData;
    if (p == 0) Req0 = 0; else Req1 = 0;
    check_val({tag, "_lat"}, got ? lat : 99, 32'd2);
    @(negedge Clock);
    check_val({tag, "_ack1cyc"}, {31'd0, (p == 0) ? Ack0 : Ack1}, 32'd0);
    $display("txn %s port=%0d wr=%0d addr=%0d wdata=%02h rdata=%02h lat=%0d",
             tag, p, wr, a, d, last_rdata, lat);
  endtask

  task automatic do_reset();
    @(negedge Clock);
    ResetN = 0;
    @(negedge Clock);
    @(negedge Clock);
    ResetN = 1;
    @(negedge Clock);
  endtask

  initial begin
    int a0c, a1c, nacks, last_cyc, order, cnt;
    bit got;
    ResetN = 0;
    Req0 = 0; Req1 = 0; Wr0 = 0; Wr1 = 0;
    Addr0 = 0; Addr1 = 0; WData0 = 0; WData1 = 0;
    last_rdata = 0;

    // 1. reset values, then read addr 2
    @(negedge Clock);
    @(negedge Clock);
    check_val("rst_ack0", {31'd0, Ack0}, 0);
    check_val("rst_ack1", {31'd0, Ack1}, 0);
    check_val("rst_rdata", {24'd0, RData}, 0);
    check_val("rst_sel", {30'd0, MemSelect}, 0);
    check_val("rst_rw", {31'd0, MemRW}, 0);
    ResetN = 1;
    @(negedge Clock);
    txn(0, 0, 2'd2, 8'h00, "s1_rd2");
    check_val("s1_rdata", {24'd0, last_rdata}, 32'h00);

    // 2. write A5 to 3, read back; other cells still zero
    txn(0, 1, 2'd3, 8'hA5, "s2_wr3");
    txn(0, 0, 2'd3, 8'h00, "s2_rd3");
    check_val("s2_rd3_data", {24'd0, last_rdata}, 32'hA5);
    txn(0, 1, 2'd0, 8'h00, "s2_wr0_dummy");
    check_val("s2_rdata_hold", {24'd0, RData}, 32'hA5);
    for (int k = 0; k < 3; k++) begin
      txn(0, 0, k[1:0], 8'h00, "s2_rdk");
      check_val("s2_rdk_data", {24'd0, last_rdata}, 32'h00);
    end

    // 3. simultaneous requests after reset: port 0 first, port 1 three later
    do_reset();
    Req0 = 1; Wr0 = 1; Addr0 = 2'd1; WData0 = 8'h11;
    Req1 = 1; Wr1 = 1; Addr1 = 2'd1; WData1 = 8'h22;
    a0c = 0; a1c = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge Clock);
      if (Ack0 && a0c == 0) begin a0c = c; Req0 = 0; end
      if (Ack1 && a1c == 0) begin a1c = c; Req1 = 0; end
      if (a0c != 0 && a1c != 0) break;
    end
    Req0 = 0; Req1 = 0;
    $display("txn s3_tie ack0_cycle=%0d ack1_cycle=%0d", a0c, a1c);
    check_val("s3_ack0_cyc", a0c, 2);
    check_val("s3_ack1_cyc", a1c, 5);
    @(negedge Clock);
    txn(0, 0, 2'd1, 8'h00, "s3_rd1");
    check_val("s3_rd1_data", {24'd0, last_rdata}, 32'h22);

    // 4. both held: grants alternate 0,1,0,1,0,1 every 3 cycles
    do_reset();
    Req0 = 1; Wr0 = 0; Addr0 = 2'd0;
    Req1 = 1; Wr1 = 0; Addr1 = 2'd1;
    nacks = 0; last_cyc = 0;
    for (int c = 1; c <= 40 && nacks < 6; c++) begin
      @(negedge Clock);
      if (Ack0 || Ack1) begin
        order = Ack1 ? 1 : 0;
        $display("txn s4_grant n=%0d port=%0d cycle=%0d", nacks, order, c);
        check_val("s4_order", order, nacks % 2);
        if (nacks > 0) check_val("s4_gap", c - last_cyc, 3);
        else           check_val("s4_first", c, 2);
        last_cyc = c;
        nacks++;
      end
    end
    Req0 = 0; Req1 = 0;
    check_val("s4_count", nacks, 6);
    @(negedge Clock);

    // 5. reset in the middle of a write ACCESS
    Req0 = 1; Wr0 = 1; Addr0 = 2'd0; WData0 = 8'hFF;
    @(posedge Clock);
    #2;
    check_val("s5_in_access_rw", {31'd0, MemRW}, 1);
    #1;
    ResetN = 0;
    Req0 = 0;
    #1;
    check_val("s5_async_rw", {31'd0, MemRW}, 0);
    check_val("s5_async_ack", {31'd0, Ack0}, 0);
    @(negedge Clock);
    check_val("s5_rst_sel", {30'd0, MemSelect}, 0);
    check_val("s5_rst_rdata", {24'd0, RData}, 0);
    ResetN = 1;
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clock);
      if (Ack0 || Ack1) cnt++;
    end
    check_val("s5_no_ack", cnt, 0);
    $display("txn s5_reset_mid_write acks_after=%0d", cnt);
    txn(0, 0, 2'd0, 8'h00, "s5_rd0");
    check_val("s5_rd0_data", {24'd0, last_rdata}, 32'h00);

    // 6. address change during ACCESS does not affect the latched write
    Req0 = 1; Wr0 = 1; Addr0 = 2'd1; WData0 = 8'h3C;
    @(posedge Clock);
    #2;
    Addr0 = 2'd2; WData0 = 8'h00; Wr0 = 0;
    got = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clock);
      if (Ack0) begin got = 1; break; end
    end
    Req0 = 0;
    check_val("s6_ack", {31'd0, got}, 1);
    $display("txn s6_wr_addr_change ack=%0d", got);
    @(negedge Clock);
    txn(0, 0, 2'd1, 8'h00, "s6_rd1");
    check_val("s6_rd1_data", {24'd0, last_rdata}, 32'h3C);
    txn(0, 0, 2'd2, 8'h00, "s6_rd2");
    check_val("s6_rd2_data", {24'd0, last_rdata}, 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
